tmds_serializer: RTL and testbench

//  Serializes parallel 10-bit TMDS symbols (3 data lanes + generated clock lane) into per-lane bitstreams
//  at bit rate, LSB first. Sits between the TMDS encoder and the per-lane fake-differential output stage.

---
 rtl/tmds_serializer_pkg.sv | 29 ++
 rtl/tmds_serializer_if.sv | 23 ++
 rtl/tmds_lane_shifter.sv | 35 +++
 rtl/tmds_serializer.sv | 127 ++++++++++++
 tb/tb_tmds_serializer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_serializer_pkg.sv
// rtl/tmds_serializer_pkg.sv - TMDS symbol constants and types shared by the serializer
package tmds_serializer_pkg;

  localparam int TMDS_SYM_W = 10;

  typedef logic [TMDS_SYM_W-1:0] tmds_sym_t;

  // Control-period symbols indexed by {C1,C0}
  localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

  // Idle filler is the C1C0=00 control symbol
  localparam tmds_sym_t TMDS_IDLE_SYM = TMDS_CTRL_00;

  // Clock lane: five ones then five zeros, LSB first
  localparam tmds_sym_t TMDS_CLK_SYM = 10'b0000011111;

  function automatic tmds_sym_t tmds_ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return TMDS_CTRL_00;
      2'b01:   return TMDS_CTRL_01;
      2'b10:   return TMDS_CTRL_10;
      default: return TMDS_CTRL_11;
    endcase
  endfunction

endpackage

// File: rtl/tmds_serializer_if.sv
// rtl/tmds_serializer_if.sv - valid/ready symbol handshake between encoder and serializer
interface tmds_serializer_if #(
  parameter int LANES = 3,
  parameter int SYM_W = 10
) ();

  logic                   i_valid;
  logic                   o_ready;
  logic [LANES*SYM_W-1:0] i_symbols;

  modport master (
    output i_valid,
    output i_symbols,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_symbols,
    output o_ready
  );

endinterface

// File: rtl/tmds_lane_shifter.sv
// rtl/tmds_lane_shifter.sv - per-lane load/shift register emitting BITS_PER_CLK bits per cycle
module tmds_lane_shifter #(
  parameter int SYM_W        = 10,
  parameter int BITS_PER_CLK = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [SYM_W-1:0]        i_sym,
  output logic [BITS_PER_CLK-1:0] o_bits
);

  logic [SYM_W-1:0] shreg_q;
  logic [SYM_W-1:0] shreg_d;

  // Load a fresh symbol on load cycles, otherwise shift out the next LSBs
  always_comb begin
    shreg_d = shreg_q >> BITS_PER_CLK;
    if (i_load) begin
      shreg_d = i_sym;
    end
  end

  // Shift register state; reset discards any partial symbol
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign o_bits = shreg_q[BITS_PER_CLK-1:0];

endmodule

// File: rtl/tmds_serializer.sv
// rtl/tmds_serializer.sv - 3-lane TMDS symbol serializer with holding register and idle insertion
module tmds_serializer
  import tmds_serializer_pkg::*;
#(
  parameter int               SYM_W        = TMDS_SYM_W,
  parameter int               LANES        = 3,
  parameter int               BITS_PER_CLK = 1,
  parameter logic [SYM_W-1:0] IDLE_SYM     = TMDS_IDLE_SYM,
  parameter logic [SYM_W-1:0] CLK_SYM      = TMDS_CLK_SYM
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  tmds_serializer_if.slave              sym_if,
  output logic [LANES*BITS_PER_CLK-1:0] o_data,
  output logic [BITS_PER_CLK-1:0]       o_clk_lane,
  output logic                          o_load,
  output logic [15:0]                   o_underflow_cnt
);

  localparam int P    = SYM_W / BITS_PER_CLK;
  localparam int PH_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(P - 1);

  if (!((BITS_PER_CLK == 1) || (BITS_PER_CLK == 2)) || ((SYM_W % BITS_PER_CLK) != 0)) begin : g_bad_bpc
    $error("tmds_serializer: BITS_PER_CLK must be 1 or 2 and divide SYM_W");
  end

  logic [PH_W-1:0]        phase_q, phase_d;
  logic [LANES*SYM_W-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   active_q, active_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   load_q;

  logic                   load;
  logic                   accept;
  logic                   insert_idle;
  logic [LANES*SYM_W-1:0] load_word;

  // Handshake: a load cycle always frees the hold slot, so ready is asserted then
  always_comb begin
    load           = (phase_q == PH_LAST);
    sym_if.o_ready = !hold_full_q || load;
    accept         = sym_if.i_valid && sym_if.o_ready;
  end

  // Next state: phase, hold register, symbol selection for the shifters, underflow count
  always_comb begin
    phase_d     = load ? '0 : phase_q + PH_W'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q || accept;
    cnt_d       = cnt_q;
    load_word   = {LANES{IDLE_SYM}};
    insert_idle = 1'b0;

    if (load) begin
      if (hold_full_q) begin
        // Hold drains into the shifters; a same-cycle accept refills it
        load_word   = hold_q;
        hold_full_d = accept;
        if (accept) begin
          hold_d = sym_if.i_symbols;
        end
      end else if (accept) begin
        load_word = sym_if.i_symbols;
      end else begin
        insert_idle = 1'b1;
      end
    end else if (accept) begin
      hold_d      = sym_if.i_symbols;
      hold_full_d = 1'b1;
    end

    // Only starvation after the first real word is an underflow
    if (insert_idle && active_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Control state registers; reset parks the phase so the first edge after reset loads
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q     <= PH_LAST;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      load_q      <= load;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tmds_lane_shifter #(
      .SYM_W        (SYM_W),
      .BITS_PER_CLK (BITS_PER_CLK)
    ) u_shifter (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load),
      .i_sym  (load_word[k*SYM_W +: SYM_W]),
      .o_bits (o_data[k*BITS_PER_CLK +: BITS_PER_CLK])
    );
  end

  tmds_lane_shifter #(
    .SYM_W        (SYM_W),
    .BITS_PER_CLK (BITS_PER_CLK)
  ) u_clk_shifter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (load),
    .i_sym  (CLK_SYM),
    .o_bits (o_clk_lane)
  );

  assign o_load          = load_q;
  assign o_underflow_cnt = cnt_q;

endmodule

// File: tb/tb_tmds_serializer.sv
// tb/tb_tmds_serializer.sv - self-checking bench for tmds_serializer
module tb_tmds_serializer;

  localparam logic [9:0] IDLE_SYM = 10'b1101010100;
  localparam logic [9:0] IDLE_SEQ = 10'b0010101011;
  localparam logic [9:0] CLK_SEQ  = 10'b1111100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  tmds_serializer_if #(.LANES(3), .SYM_W(10)) if_a ();
  tmds_serializer_if #(.LANES(3), .SYM_W(10)) if_b ();
  tmds_serializer_if #(.LANES(1), .SYM_W(2))  if_c ();

  logic [2:0]  data_a;
  logic        clk_a;
  logic        load_a;
  logic [15:0] cnt_a;
  logic [5:0]  data_b;
  logic [1:0]  clk_b;
  logic        load_b;
  logic [15:0] cnt_b;
  logic [1:0]  data_c;
  logic [1:0]  clk_c;
  logic        load_c;
  logic [15:0] cnt_c;

  tmds_serializer #(.LANES(3), .BITS_PER_CLK(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .sym_if(if_a.slave),
    .o_data(data_a), .o_clk_lane(clk_a), .o_load(load_a), .o_underflow_cnt(cnt_a)
  );

  tmds_serializer #(.LANES(3), .BITS_PER_CLK(2)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .sym_if(if_b.slave),
    .o_data(data_b), .o_clk_lane(clk_b), .o_load(load_b), .o_underflow_cnt(cnt_b)
  );

  tmds_serializer #(.SYM_W(2), .LANES(1), .BITS_PER_CLK(2), .IDLE_SYM(2'b01), .CLK_SYM(2'b10)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .sym_if(if_c.slave),
    .o_data(data_c), .o_clk_lane(clk_c), .o_load(load_c), .o_underflow_cnt(cnt_c)
  );

  typedef struct {
    logic [2:0]  d;
    logic        c;
    logic        ld;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [9:0] l0;
    logic [9:0] l1;
    logic [9:0] l2;
    logic [9:0] l0_seq;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[4];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_sym(input logic [9:0] seq0, input logic [9:0] w1, input logic [9:0] w2,
                          input logic [15:0] cnt);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.d   = {w2[i], w1[i], seq0[9-i]};
      e.c   = CLK_SEQ[9-i];
      e.ld  = (i == 0);
      e.cnt = cnt;
      sb.push_back(e);
    end
  endtask

  task automatic step_a();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_underrun: got empty queue expected an entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      check("data_a", data_a, e.d);
      check("clk_lane_a", clk_a, e.c);
      check("load_a", load_a, e.ld);
      check("underflow_cnt_a", cnt_a, e.cnt);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    if_a.i_valid = 1'b0;
    if_a.i_symbols = '0;
    repeat (2) @(negedge clk);
    check("rst_data_a", data_a, 3'b000);
    check("rst_clk_a", clk_a, 1'b0);
    check("rst_load_a", load_a, 1'b0);
    check("rst_cnt_a", cnt_a, 16'd0);
    check("rst_ready_a", if_a.o_ready, 1'b1);
    sb.delete();
    rst_a = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    logic       rdy;
    logic       acc;
    logic [1:0] pairs [5];
    logic [1:0] clkp  [5];
    logic [1:0] idlep [5];

    tbl[0] = '{l0: 10'h3FF, l1: 10'h155, l2: 10'h0F0, l0_seq: 10'b1111111111};
    tbl[1] = '{l0: 10'h000, l1: 10'h2AA, l2: 10'h30C, l0_seq: 10'b0000000000};
    tbl[2] = '{l0: 10'h2AA, l1: 10'h3FF, l2: 10'h001, l0_seq: 10'b0101010101};
    tbl[3] = '{l0: 10'h155, l1: 10'h000, l2: 10'h200, l0_seq: 10'b1010101010};

    if_a.i_valid = 1'b0; if_a.i_symbols = '0;
    if_b.i_valid = 1'b0; if_b.i_symbols = '0;
    if_c.i_valid = 1'b0; if_c.i_symbols = '0;

    // Idle stream after reset, uncounted
    reset_a();
    for (int s = 0; s < 3; s++) push_sym(IDLE_SEQ, IDLE_SYM, IDLE_SYM, 16'd0);
    for (int c = 0; c < 30; c++) step_a();

    // Continuous stream of three words: bypass, hold, hold refill on load
    reset_a();
    for (int w = 0; w < 3; w++) push_sym(tbl[w].l0_seq, tbl[w].l1, tbl[w].l2, 16'd0);
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 3) begin
        if_a.i_valid = 1'b1;
        if_a.i_symbols = {tbl[idx].l2, tbl[idx].l1, tbl[idx].l0};
      end else begin
        if_a.i_valid = 1'b0;
        if_a.i_symbols = 'x;
      end
      rdy = if_a.o_ready;
      check("ready_stream", rdy, (c <= 1) || (c % 10 == 0) || (c > 20));
      acc = if_a.i_valid && rdy;
      step_a();
      if (acc) idx++;
    end

    // One word then starvation: each idle symbol counts
    reset_a();
    push_sym(tbl[3].l0_seq, tbl[3].l1, tbl[3].l2, 16'd0);
    for (int s = 1; s <= 3; s++) push_sym(IDLE_SEQ, IDLE_SYM, IDLE_SYM, 16'(s));
    if_a.i_valid = 1'b1;
    if_a.i_symbols = {tbl[3].l2, tbl[3].l1, tbl[3].l0};
    step_a();
    if_a.i_valid = 1'b0;
    if_a.i_symbols = 'x;
    for (int c = 0; c < 39; c++) step_a();

    // Reset mid-symbol at phase 4
    reset_a();
    push_sym(tbl[0].l0_seq, tbl[0].l1, tbl[0].l2, 16'd0);
    if_a.i_valid = 1'b1;
    if_a.i_symbols = {tbl[0].l2, tbl[0].l1, tbl[0].l0};
    step_a();
    if_a.i_valid = 1'b0;
    for (int c = 0; c < 4; c++) step_a();
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_data_a", data_a, 3'b000);
    check("midrst_clk_a", clk_a, 1'b0);
    check("midrst_load_a", load_a, 1'b0);
    check("midrst_cnt_a", cnt_a, 16'd0);
    sb.delete();
    rst_a = 1'b0;
    push_sym(IDLE_SEQ, IDLE_SYM, IDLE_SYM, 16'd0);
    for (int c = 0; c < 10; c++) step_a();

    // Two bits per clock
    pairs = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
    clkp  = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    idlep = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    repeat (2) @(negedge clk);
    check("rst_data_b", data_b, 6'd0);
    check("rst_ready_b", if_b.o_ready, 1'b1);
    rst_b = 1'b0;
    if_b.i_valid = 1'b1;
    if_b.i_symbols = {10'h000, 10'h000, 10'b1100110010};
    @(posedge clk);
    @(negedge clk);
    if_b.i_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("ddr_lane0", data_b[1:0], (c < 5) ? pairs[c] : idlep[c-5]);
      check("ddr_clk_lane", clk_b, clkp[c % 5]);
      check("ddr_load", load_b, (c % 5) == 0);
      check("ddr_cnt", cnt_b, (c < 5) ? 16'd0 : 16'd1);
      if (c < 5) check("ddr_lanes12", data_b[5:2], 4'd0);
      @(posedge clk);
      @(negedge clk);
    end

    // Underflow counter saturation (one-phase instance, one insertion per cycle)
    rst_c = 1'b0;
    if_c.i_valid = 1'b1;
    if_c.i_symbols = 2'b11;
    @(posedge clk);
    @(negedge clk);
    check("sat_word", data_c, 2'b11);
    check("sat_cnt0", cnt_c, 16'd0);
    if_c.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_cnt3", cnt_c, 16'd3);
    check("sat_idle", data_c, 2'b01);
    check("sat_clk", clk_c, 2'b10);
    check("sat_load", load_c, 1'b1);
    repeat (65531) @(posedge clk);
    @(negedge clk);
    check("sat_cnt_fffe", cnt_c, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check("sat_cnt_ffff", cnt_c, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_cnt_stick", cnt_c, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
